// File: rtl/spi_txn_arbiter_pkg.sv
// spi_arb_pkg: shared types and constants for the SPI transaction arbiter.
//   - arb_state_e   : arbiter FSM states (idle, transfer, release)
//   - READ_MODE / WRITE_MODE, MB_* : command header bits
//   - ADXL345 register addresses, kept in step with spi_param.h
//   - DEF_CMD_W / DEF_DATA_W : default command and read-data widths
//   - mk_cmd()      : packs {R/W, MB, addr[5:0], wdata[7:0]}
package spi_arb_pkg;

    localparam int unsigned DEF_CMD_W  = 16;
    localparam int unsigned DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StRelease
    } arb_state_e;

    localparam logic READ_MODE  = 1'b1;
    localparam logic WRITE_MODE = 1'b0;
    localparam logic MB_SINGLE  = 1'b0;
    localparam logic MB_MULTI   = 1'b1;

    localparam logic [5:0] ADDR_DEVID       = 6'h00;
    localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
    localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADDR_INT_ENABLE  = 6'h2E;
    localparam logic [5:0] ADDR_INT_MAP     = 6'h2F;
    localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
    localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [5:0] ADDR_DATAX0      = 6'h32;

    function automatic logic [15:0] mk_cmd(input logic       mode,
                                           input logic       mb,
                                           input logic [5:0] addr,
                                           input logic [7:0] wdata);
        return {mode, mb, addr, wdata};
    endfunction

endpackage

// File: rtl/spi_txn_arbiter_if.sv
// spi_txn_arbiter_if: bundles the requester side and the spi_controller engine
// side of the arbiter.
//   Requester side : iREQ, iCMD (flattened, requester i at [i*CMD_W +: CMD_W]),
//                    oGNT, oDONE, oERR, oRDATA, oBUSY
//   Engine side    : oP2S_DATA, oSPI_GO, iSPI_END, iS2P_DATA
//   master modport : the environment (requesters + engine) driving the arbiter
//   slave modport  : the arbiter itself
interface spi_txn_arbiter_if
    import spi_arb_pkg::*;
#(
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned CMD_W  = DEF_CMD_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic [N_REQ-1:0]       iREQ;
    logic [N_REQ*CMD_W-1:0] iCMD;
    logic [N_REQ-1:0]       oGNT;
    logic [N_REQ-1:0]       oDONE;
    logic [N_REQ-1:0]       oERR;
    logic [DATA_W-1:0]      oRDATA;
    logic                   oBUSY;
    logic [CMD_W-1:0]       oP2S_DATA;
    logic                   oSPI_GO;
    logic                   iSPI_END;
    logic [DATA_W-1:0]      iS2P_DATA;

    modport master (
        output iREQ, iCMD, iSPI_END, iS2P_DATA,
        input  oGNT, oDONE, oERR, oRDATA, oBUSY, oP2S_DATA, oSPI_GO
    );

    modport slave (
        input  iREQ, iCMD, iSPI_END, iS2P_DATA,
        output oGNT, oDONE, oERR, oRDATA, oBUSY, oP2S_DATA, oSPI_GO
    );

endinterface

// File: rtl/spi_txn_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req_i   : request vector
//   ptr_i   : highest-priority index; search runs ptr_i, ptr_i+1, ... wrapping
//   gnt_o   : one-hot winner
//   idx_o   : binary index of the winner
//   valid_o : at least one request present
module rr_pick
    import spi_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             valid_o
);

    logic [PTR_W-1:0] j;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            j = PTR_W'((32'(ptr_i) + k) % N_REQ);
            if (!valid_o && req_i[j]) begin
                valid_o  = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin sharing of one spi_controller transaction
// engine between N_REQ requesters (index 0 = init sequencer).
//   iSPI_CLK : the only clock
//   iRST     : asynchronous active-high reset
//   bus      : slave modport of spi_txn_arbiter_if (requests, commands,
//              grant/done/err pulses, read byte, engine go/end handshake)
// All outputs come straight from flops.
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned CMD_W  = DEF_CMD_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned TO_W   = 12
) (
    input logic              iSPI_CLK,
    input logic              iRST,
    spi_txn_arbiter_if.slave bus
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // Fire when the counter is about to reach all-ones: the timeout edge
    // lands exactly 2^TO_W-1 cycles after the grant.
    localparam logic [TO_W-1:0] WD_FIRE = {TO_W{1'b1}} - TO_W'(1);

    arb_state_e        state_q;
    logic [PTR_W-1:0]  ptr_q;
    logic [N_REQ-1:0]  gnt_q;
    logic [N_REQ-1:0]  done_q;
    logic [N_REQ-1:0]  err_q;
    logic [DATA_W-1:0] rdata_q;
    logic              busy_q;
    logic [CMD_W-1:0]  p2s_q;
    logic              go_q;
    logic [TO_W-1:0]   wd_q;

    logic [N_REQ-1:0]  pick_gnt;
    logic [PTR_W-1:0]  pick_idx;
    logic              pick_valid;
    logic [CMD_W-1:0]  cmd_sel;
    logic [PTR_W-1:0]  ptr_next;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req_i   (bus.iREQ),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        cmd_sel  = bus.iCMD[32'(pick_idx) * CMD_W +: CMD_W];
        ptr_next = PTR_W'((32'(pick_idx) + 32'd1) % N_REQ);
    end

    always_ff @(posedge iSPI_CLK or posedge iRST) begin
        if (iRST) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            p2s_q   <= '0;
            go_q    <= 1'b0;
            wd_q    <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        gnt_q   <= pick_gnt;
                        p2s_q   <= cmd_sel;
                        go_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        wd_q    <= '0;
                        ptr_q   <= ptr_next;
                        state_q <= StXfer;
                    end
                end
                StXfer: begin
                    if (bus.iSPI_END) begin
                        // Captured for writes too; requesters ignore it.
                        rdata_q <= bus.iS2P_DATA;
                        done_q  <= gnt_q;
                        go_q    <= 1'b0;
                        wd_q    <= '0;
                        state_q <= StRelease;
                    end else if (wd_q == WD_FIRE) begin
                        // Hung engine: finish with error, keep old rdata.
                        done_q  <= gnt_q;
                        err_q   <= gnt_q;
                        go_q    <= 1'b0;
                        wd_q    <= '0;
                        state_q <= StRelease;
                    end else begin
                        wd_q <= wd_q + TO_W'(1);
                    end
                end
                StRelease: begin
                    // Hold the grant until the engine drops its end flag.
                    if (!bus.iSPI_END) begin
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (wd_q == WD_FIRE) begin
                        err_q   <= gnt_q;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        wd_q    <= '0;
                        state_q <= StIdle;
                    end else begin
                        wd_q <= wd_q + TO_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.oGNT      = gnt_q;
    assign bus.oDONE     = done_q;
    assign bus.oERR      = err_q;
    assign bus.oRDATA    = rdata_q;
    assign bus.oBUSY     = busy_q;
    assign bus.oP2S_DATA = p2s_q;
    assign bus.oSPI_GO   = go_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter; expected completions are queued when a
// grant is accepted and popped when oDONE pulses.
module tb_spi_txn_arbiter;
    import spi_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_txn_arbiter_if #(.N_REQ(3), .CMD_W(16), .DATA_W(8)) bus ();

    spi_txn_arbiter #(
        .N_REQ  (3),
        .CMD_W  (16),
        .DATA_W (8),
        .TO_W   (12)
    ) dut (
        .iSPI_CLK (clk),
        .iRST     (rst),
        .bus      (bus)
    );

    typedef struct {
        logic [2:0] done;
        logic [2:0] err;
        logic [7:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          vecs = 0;
    int          errs = 0;
    logic [15:0] cmd[3];
    logic        bad;
    int          order[4] = '{0, 1, 2, 0};

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vecs++;
        assert (obs === want) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic set_cmds();
        bus.iCMD = {cmd[2], cmd[1], cmd[0]};
    endtask

    task automatic push(input int idx, input logic [7:0] rd, input bit is_err);
        exp_t e;
        e.done  = 3'b001 << idx;
        e.err   = is_err ? e.done : 3'b000;
        e.rdata = rd;
        sb.push_back(e);
    endtask

    task automatic check_done_now();
        exp_t e;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("done", 32'(bus.oDONE), 32'(e.done));
            chk("err", 32'(bus.oERR), 32'(e.err));
            chk("rdata", 32'(bus.oRDATA), 32'(e.rdata));
            chk("go_low_at_done", 32'(bus.oSPI_GO), 32'd0);
        end
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (bus.oDONE == 3'b000 && n < bound) begin
            tick();
            n++;
        end
        chk("done_within_bound", 32'(bus.oDONE != 3'b000), 32'd1);
        check_done_now();
    endtask

    task automatic wait_grant(input int bound);
        int n = 0;
        while (bus.oGNT == 3'b000 && n < bound) begin
            tick();
            n++;
        end
        chk("grant_within_bound", 32'(bus.oGNT != 3'b000), 32'd1);
    endtask

    // Called on the oDONE cycle after the requester has reacted.
    task automatic finish_release();
        bus.iSPI_END = 1'b0;
        tick();
        chk("done_one_cycle", 32'(bus.oDONE), 32'd0);
        chk("gnt_cleared", 32'(bus.oGNT), 32'd0);
        chk("busy_cleared", 32'(bus.oBUSY), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.iREQ      = '0;
        bus.iSPI_END  = 1'b0;
        bus.iS2P_DATA = '0;
        cmd[0] = '0; cmd[1] = '0; cmd[2] = '0;
        set_cmds();
        tick();
        tick();

        // Reset state
        chk("rst_gnt", 32'(bus.oGNT), 32'd0);
        chk("rst_done", 32'(bus.oDONE), 32'd0);
        chk("rst_err", 32'(bus.oERR), 32'd0);
        chk("rst_rdata", 32'(bus.oRDATA), 32'd0);
        chk("rst_busy", 32'(bus.oBUSY), 32'd0);
        chk("rst_p2s", 32'(bus.oP2S_DATA), 32'd0);
        chk("rst_go", 32'(bus.oSPI_GO), 32'd0);
        rst = 1'b0;
        tick();

        // Single request, 40-cycle engine
        cmd[0] = 16'h2C09;
        set_cmds();
        bus.iREQ = 3'b001;
        tick();
        chk("single_gnt", 32'(bus.oGNT), 32'h1);
        chk("single_go", 32'(bus.oSPI_GO), 32'd1);
        chk("single_p2s", 32'(bus.oP2S_DATA), 32'h2C09);
        chk("single_busy", 32'(bus.oBUSY), 32'd1);
        push(0, 8'hAB, 1'b0);
        bad = 1'b0;
        repeat (40) begin
            tick();
            if (bus.oGNT != 3'b001 || bus.oDONE != 3'b000 || bus.oSPI_GO != 1'b1) bad = 1'b1;
        end
        chk("single_gnt_held", 32'(bad), 32'd0);
        bus.iS2P_DATA = 8'hAB;
        bus.iSPI_END  = 1'b1;
        wait_done(4);
        bus.iREQ = 3'b000;
        finish_release();

        // Contention from a fresh pointer: order 0,1,2,0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmd[0] = mk_cmd(WRITE_MODE, MB_SINGLE, ADDR_POWER_CTL, 8'h08);
        cmd[1] = mk_cmd(READ_MODE, MB_SINGLE, ADDR_DATAX0, 8'h00);
        cmd[2] = mk_cmd(READ_MODE, MB_SINGLE, ADDR_INT_SOURCE, 8'h00);
        set_cmds();
        bus.iREQ = 3'b111;
        for (int t = 0; t < 4; t++) begin
            wait_grant(5);
            chk("rr_gnt", 32'(bus.oGNT), 32'(3'b001 << order[t]));
            chk("rr_p2s", 32'(bus.oP2S_DATA), 32'(cmd[order[t]]));
            push(order[t], 8'(8'h10 + t), 1'b0);
            repeat (3 + t) tick();
            bus.iS2P_DATA = 8'(8'h10 + t);
            bus.iSPI_END  = 1'b1;
            wait_done(4);
            if (t == 3) bus.iREQ = 3'b000;
            finish_release();
        end

        // Hung engine on requester 1: timeout 4095 cycles after grant
        bus.iS2P_DATA = 8'hEE;
        bus.iREQ      = 3'b010;
        wait_grant(5);
        chk("hung_gnt", 32'(bus.oGNT), 32'h2);
        push(1, 8'h13, 1'b1);
        bad = 1'b0;
        for (int k = 1; k <= 4094; k++) begin
            tick();
            if (bus.oDONE != 3'b000 || bus.oERR != 3'b000 || bus.oSPI_GO != 1'b1) bad = 1'b1;
        end
        chk("hung_no_early_timeout", 32'(bad), 32'd0);
        tick();
        check_done_now();
        bus.iREQ = 3'b000;
        tick();
        chk("hung_err_one_cycle", 32'(bus.oERR), 32'd0);
        chk("hung_released", 32'(bus.oGNT), 32'd0);

        // Next request served; engine holds END for 10 cycles after GO drops
        bus.iREQ = 3'b100;
        wait_grant(5);
        chk("sticky_gnt", 32'(bus.oGNT), 32'h4);
        push(2, 8'h5A, 1'b0);
        repeat (2) tick();
        bus.iS2P_DATA = 8'h5A;
        bus.iSPI_END  = 1'b1;
        wait_done(4);
        bus.iREQ = 3'b001;
        bad = 1'b0;
        repeat (10) begin
            tick();
            if (bus.oGNT != 3'b100 || bus.oBUSY != 1'b1 || bus.oSPI_GO != 1'b0) bad = 1'b1;
        end
        chk("sticky_no_new_grant", 32'(bad), 32'd0);
        bus.iSPI_END = 1'b0;
        tick();
        chk("sticky_idle_gnt", 32'(bus.oGNT), 32'd0);
        chk("sticky_idle_busy", 32'(bus.oBUSY), 32'd0);
        tick();
        chk("after_sticky_gnt", 32'(bus.oGNT), 32'h1);

        // Reset in the middle of requester 0's transfer
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_go", 32'(bus.oSPI_GO), 32'd0);
        chk("arst_gnt", 32'(bus.oGNT), 32'd0);
        chk("arst_busy", 32'(bus.oBUSY), 32'd0);
        tick();
        rst      = 1'b0;
        bus.iREQ = 3'b000;
        bad      = 1'b0;
        repeat (3) begin
            tick();
            if (bus.oDONE != 3'b000) bad = 1'b1;
        end
        chk("arst_no_done", 32'(bad), 32'd0);
        bus.iREQ = 3'b111;
        wait_grant(5);
        chk("arst_ptr_zero", 32'(bus.oGNT), 32'h1);
        push(0, 8'h77, 1'b0);
        tick();
        bus.iS2P_DATA = 8'h77;
        bus.iSPI_END  = 1'b1;
        wait_done(4);
        bus.iREQ = 3'b000;
        finish_release();

        // Requester 2 withdraws and changes its command after the grant
        cmd[2] = mk_cmd(WRITE_MODE, MB_SINGLE, ADDR_INT_ENABLE, 8'h80);
        set_cmds();
        bus.iREQ = 3'b100;
        wait_grant(5);
        chk("wd_gnt", 32'(bus.oGNT), 32'h4);
        chk("wd_p2s", 32'(bus.oP2S_DATA), 32'h2E80);
        push(2, 8'hC3, 1'b0);
        bus.iREQ = 3'b000;
        cmd[2]   = 16'hFFFF;
        set_cmds();
        repeat (4) tick();
        chk("wd_gnt_kept", 32'(bus.oGNT), 32'h4);
        chk("wd_p2s_latched", 32'(bus.oP2S_DATA), 32'h2E80);
        bus.iS2P_DATA = 8'hC3;
        bus.iSPI_END  = 1'b1;
        wait_done(4);
        finish_release();
        tick();
        chk("p2s_holds_after_txn", 32'(bus.oP2S_DATA), 32'h2E80);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/spi_txn_arbiter.md
# spi_txn_arbiter

Round-robin scheduler that shares the single `spi_controller` transaction engine between several requesters: the ADXL345 init sequencer, the axis data poller and the INT_SOURCE reader. Each requester presents a 16-bit `{mode, register, data}` command. The arbiter grants one requester at a time and drives the engine's go/end handshake. It returns the read byte with a per-requester done pulse, and a watchdog recovers from a hung transfer.

## Interface
Parameters:
- N_REQ, 3, number of requesters; index 0 is the init sequencer.
- CMD_W, 16, command width `{R/W, MB, addr[5:0], wdata[7:0]}`.
- DATA_W, 8, read data width.
- TO_W, 12, watchdog counter width; timeout occurs at 2^TO_W-1 cycles.

Ports:
- iSPI_CLK  in  1  control clock, the only clock.
- iRST  in  1  reset, asynchronous, active-high.
- iREQ  in  N_REQ  request level; held by the requester until its oDONE bit pulses.
- iCMD  in  N_REQ*CMD_W  flattened commands; requester i occupies bits [i*CMD_W +: CMD_W].
- oGNT  out  N_REQ  one-hot grant, held for the whole transaction.
- oDONE  out  N_REQ  one-cycle completion pulse to the granted requester.
- oERR  out  N_REQ  one-cycle timeout pulse, coincident with oDONE.
- oRDATA  out  DATA_W  last received byte.
- oBUSY  out  1  high whenever the state is not IDLE.
- oP2S_DATA  out  CMD_W  command to the engine.
- oSPI_GO  out  1  engine start level.
- iSPI_END  in  1  engine end flag.
- iS2P_DATA  in  DATA_W  engine received byte.

## Operation
- States: IDLE, XFER, RELEASE.
- **IDLE**
  - If any iREQ bit is set, the round-robin pick selects a winner, searching from ptr upward with wrap at N_REQ-1 to 0.
  - Next cycle: oGNT set to the winner, oP2S_DATA latched from the winner's iCMD, oSPI_GO=1, watchdog cleared, state XFER.
  - ptr is loaded with winner+1 (mod N_REQ).
- **XFER**
  - On iSPI_END=1: oRDATA<=iS2P_DATA, oDONE[win]=1 for one cycle, oSPI_GO=0, state RELEASE.
  - The read byte is captured for write commands too; requesters ignore it.
- **RELEASE**
  - Wait for iSPI_END=0, then clear oGNT and go to IDLE.
  - No new grant is issued until the engine has dropped its end flag.
- **Watchdog**
  - Counts in XFER and RELEASE.
  - On reaching all-ones in XFER: oSPI_GO=0, oDONE[win] and oERR[win] pulse together, oRDATA is unchanged, state RELEASE, counter cleared.
  - On reaching all-ones in RELEASE: force IDLE and pulse oERR[win] alone.
- **Request rules**
  - If iREQ drops mid-transaction, it is ignored and the transfer completes normally.
  - iCMD changes after the grant have no effect, because the command is latched.
  - A requester that still holds iREQ after oDONE is a new request and competes under round-robin.
- **Simultaneous requests:** exactly one wins, and a waiting requester is served within N_REQ transactions.
- **oP2S_DATA** holds its value after the transaction until the next grant.

## Timing
- Reset values: oGNT=0, oDONE=0, oERR=0, oRDATA=0, oBUSY=0, oP2S_DATA=0, oSPI_GO=0, ptr=0, state IDLE, watchdog=0.
- **Reset mid-operation:** oSPI_GO drops asynchronously and no oDONE is issued for the aborted transfer.
- **Latencies:**
  - iREQ high in IDLE → oGNT and oSPI_GO at the next edge (1 cycle).
  - iSPI_END rising → oDONE, oSPI_GO=0 and oRDATA updated at the next edge.
  - iSPI_END falling → IDLE at the next edge.
  - Back-to-back: the earliest next grant is 1 cycle after entering IDLE.
  - Minimum spacing between grants is 3 cycles plus the engine time.
- All outputs are registered, and there are no combinational paths from inputs to outputs.

## Structure
- Package `spi_arb_pkg`:
  - state enum (IDLE, XFER, RELEASE);
  - READ_MODE/WRITE_MODE and register-address constants shared with spi_param.h;
  - the CMD_W and DATA_W defaults.
- Sub-module `rr_pick`:
  - combinational round-robin selector;
  - inputs are the request vector and ptr; outputs are a one-hot winner plus a valid flag.

## Test plan
- Single request: iREQ=3'b001, iCMD[0]=16'h2C09, engine model asserts END after 40 cycles with S2P=8'hAB → oGNT=001 for the whole transfer, P2S=16'h2C09, oDONE[0] pulses one cycle, oRDATA=8'hAB, no oERR.
- Contention: iREQ=3'b111 held throughout → grant order 0,1,2,0; each oDONE bit pulses exactly once per grant.
- Hung engine: END never asserted → exactly 4095 cycles after grant, oSPI_GO=0, oDONE[1] and oERR[1] pulse, oRDATA unchanged, next request is served.
- Sticky END: engine holds END 10 cycles after GO drops → no new grant until END=0; then IDLE.
- Reset during XFER: iRST pulsed mid-transfer → oSPI_GO, oGNT and oBUSY at 0 immediately, no oDONE, ptr=0; the next request is granted normally.
- Request withdrawn: iREQ[2] dropped after grant → transfer completes and oDONE[2] still pulses.
